// File: rtl/orb_pkg.sv
// Shared definitions for the orbital frame reader: default geometry, marker pattern,
// reader FSM states and the marker-bit lookup helper.
package orb_pkg;

    localparam int unsigned ORB_WORD_W      = 12;
    localparam int unsigned ORB_ADDR_W      = 11;
    localparam int unsigned ORB_FRAME_WORDS = 2048;
    localparam int unsigned ORB_DIV         = 20;
    localparam logic [15:0] ORB_MARKER      = 16'hF2B4;

    typedef enum logic [1:0] {
        StIdle,
        StPrime,
        StShift
    } readerState_e;

    // Marker bit carried in bit 0 of the word at index idx within the frame (MSB of marker first).
    function automatic logic markerBit(input logic [15:0] marker, input logic [3:0] idx);
        return marker[4'd15 - idx];
    endfunction

endpackage

// File: rtl/orb_bit_timer.sv
// Bit-cell timer: counts DIV clocks per serial bit while running and flags the first
// clock of each cell and the half-cell point (used for the Manchester phase flip).
module orb_bit_timer #(
    parameter int unsigned DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic cellStart,
    output logic cellMid
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CntW-1:0] cnt;

    // Free-running 0..DIV-1 counter, held at 0 whenever the serialiser is not running.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
        end else if (cnt == CntW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign cellStart = run && (cnt == '0);
    assign cellMid   = run && (cnt == CntW'(DIV / 2));

endmodule

// File: rtl/orb_frame_reader.sv
// Frame reader: fetches words from the shared frame RAM, replaces bit 0 with the frame
// marker bit, serialises MSB-first at DIV clocks per bit and toggles SW at each frame start.
// Build option: define MANCHESTER_EN for Manchester line coding (default NRZ).
module orb_frame_reader
    import orb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ORB_ADDR_W,
    parameter int unsigned WORD_W      = ORB_WORD_W,
    parameter int unsigned FRAME_WORDS = ORB_FRAME_WORDS,
    parameter int unsigned DIV         = ORB_DIV,
    parameter logic [15:0] MARKER      = ORB_MARKER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WORD_W-1:0] RdData,
    output logic [ADDR_W-1:0] RdAddr,
    output logic              RE,
    output logic              SW,
    output logic              serOut,
    output logic              bitStrobe,
    output logic              frameStart
);

    localparam int unsigned BitW = $clog2(WORD_W);

`ifdef MANCHESTER_EN
    // First half of each cell carries the inverted bit.
    localparam logic ManchInv = 1'b1;
`else
    localparam logic ManchInv = 1'b0;
`endif

    readerState_e      state;
    logic              fetchPend;
    logic [WORD_W-1:0] buffer;
    logic [WORD_W-1:0] shifter;
    logic [ADDR_W-1:0] wordIdx;
    logic [BitW-1:0]   bitCnt;
    logic              curBit;
    logic              stopReq;
    logic              cellStart;
    logic              cellMid;

    logic              lastWord;
    logic [ADDR_W-1:0] nextIdx;
    logic [WORD_W-1:0] loadWord;
    logic              unusedLsb;

    orb_bit_timer #(
        .DIV (DIV)
    ) uBitTimer (
        .clk       (clk),
        .rst       (rst),
        .run       (state == StShift),
        .cellStart (cellStart),
        .cellMid   (cellMid)
    );

    // The stored LSB is never sent: the marker bit takes its place.
    assign unusedLsb = buffer[0];

    // Word sequencing and the marked word that loads the shifter.
    always_comb begin
        lastWord = (wordIdx == ADDR_W'(FRAME_WORDS - 1));
        nextIdx  = lastWord ? '0 : wordIdx + 1'b1;
        loadWord = {buffer[WORD_W-1:1], markerBit(MARKER, wordIdx[3:0])};
    end

    // Reader FSM: fetch, prefetch, serialise and frame toggling, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            fetchPend  <= 1'b0;
            buffer     <= '0;
            shifter    <= '0;
            wordIdx    <= '0;
            bitCnt     <= '0;
            curBit     <= 1'b0;
            stopReq    <= 1'b0;
            RdAddr     <= '0;
            RE         <= 1'b0;
            SW         <= 1'b0;
            serOut     <= 1'b0;
            bitStrobe  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            RE         <= 1'b0;
            bitStrobe  <= 1'b0;
            frameStart <= 1'b0;
            // RdData is valid the clock after the RE pulse has been seen by the RAM.
            fetchPend  <= RE;
            if (fetchPend) begin
                buffer <= RdData;
            end
            if (cellMid) begin
                serOut <= curBit;
            end
            unique case (state)
                StIdle: begin
                    if (en) begin
                        RE      <= 1'b1;
                        RdAddr  <= '0;
                        wordIdx <= '0;
                        bitCnt  <= '0;
                        stopReq <= 1'b0;
                        state   <= StPrime;
                    end
                end
                StPrime: begin
                    if (fetchPend) begin
                        state <= StShift;
                    end
                end
                StShift: begin
                    if (cellStart) begin
                        if (bitCnt == '0) begin
                            if (stopReq) begin
                                // Last bit of the frame has finished: park the line.
                                state   <= StIdle;
                                serOut  <= 1'b0;
                                RdAddr  <= '0;
                                stopReq <= 1'b0;
                            end else begin
                                shifter   <= loadWord << 1;
                                curBit    <= loadWord[WORD_W-1];
                                serOut    <= loadWord[WORD_W-1] ^ ManchInv;
                                bitStrobe <= 1'b1;
                                bitCnt    <= BitW'(1);
                                if (wordIdx == '0) begin
                                    SW         <= ~SW;
                                    frameStart <= 1'b1;
                                end
                                wordIdx <= nextIdx;
                                // en only matters when the next fetch would begin a new frame.
                                if (lastWord && !en) begin
                                    stopReq <= 1'b1;
                                end else begin
                                    RE     <= 1'b1;
                                    RdAddr <= nextIdx;
                                end
                            end
                        end else begin
                            curBit    <= shifter[WORD_W-1];
                            serOut    <= shifter[WORD_W-1] ^ ManchInv;
                            shifter   <= shifter << 1;
                            bitStrobe <= 1'b1;
                            bitCnt    <= (bitCnt == BitW'(WORD_W - 1)) ? '0 : bitCnt + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_orb_frame_reader.sv
// Scoreboard bench for orb_frame_reader: expected bit stream and fetch addresses are
// queued from a frame-level model; a negedge monitor pops and compares on each DUT event.
module tb_orb_frame_reader;

    localparam int unsigned ADDR_W      = 11;
    localparam int unsigned WORD_W      = 12;
    localparam int unsigned FRAME_WORDS = 32;
    localparam int unsigned DIV         = 4;
    localparam logic [15:0] MARKER      = 16'hF2B4;
`ifdef MANCHESTER_EN
    localparam bit MANCH = 1'b1;
`else
    localparam bit MANCH = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic fs;
        logic first;
    } bitExp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [WORD_W-1:0] RdData;
    logic [ADDR_W-1:0] RdAddr;
    logic              RE;
    logic              SW;
    logic              serOut;
    logic              bitStrobe;
    logic              frameStart;

    logic [WORD_W-1:0] ram [FRAME_WORDS];
    bitExp_t           bitQ [$];
    int                reQ [$];

    int   compared   = 0;
    int   mismatched = 0;
    int   frameCnt   = 0;
    int   bitInFrame = 0;
    int   sinceStrobe = 0;
    logic pendHalf   = 1'b0;
    logic curBit     = 1'b0;
    logic swExp      = 1'b0;
    logic prevRe     = 1'b0;

    always #5 clk = ~clk;

    orb_frame_reader #(
        .ADDR_W      (ADDR_W),
        .WORD_W      (WORD_W),
        .FRAME_WORDS (FRAME_WORDS),
        .DIV         (DIV),
        .MARKER      (MARKER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .RdData     (RdData),
        .RdAddr     (RdAddr),
        .RE         (RE),
        .SW         (SW),
        .serOut     (serOut),
        .bitStrobe  (bitStrobe),
        .frameStart (frameStart)
    );

    // RAM with one-clock read latency; the data bus carries junk whenever no read is issued.
    always @(posedge clk) begin
        if (RE) RdData <= ram[RdAddr[4:0]];
        else    RdData <= WORD_W'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compares every RE pulse and every bit cell against the queued expectations.
    always @(negedge clk) begin
        bitExp_t it;
        if (rst) begin
            pendHalf    = 1'b0;
            swExp       = 1'b0;
            prevRe      = 1'b0;
            sinceStrobe = 0;
        end else begin
            if (RE) begin
                check("re_pulse_width", prevRe, 0);
                if (reQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL re_stray: RE at addr %0d, expected no fetch", RdAddr);
                end else begin
                    check("re_addr", RdAddr, reQ.pop_front());
                end
            end
            prevRe = RE;
            if (frameStart) check("fs_with_strobe", bitStrobe, 1);
            sinceStrobe++;
            if (pendHalf && sinceStrobe == DIV / 2) begin
                check("ser_second_half", serOut, curBit);
                pendHalf = 1'b0;
            end
            if (bitStrobe) begin
                if (bitQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL strobe_stray: bitStrobe with serOut=%0b, expected idle", serOut);
                end else begin
                    it = bitQ.pop_front();
                    if (!it.first) check("strobe_gap", sinceStrobe, DIV);
                    check("frame_start", frameStart, it.fs);
                    if (it.fs) begin
                        swExp      = ~swExp;
                        frameCnt++;
                        bitInFrame = 0;
                    end
                    check("sw_level", SW, swExp);
                    check("ser_first_half", serOut, it.b ^ MANCH);
                    curBit   = it.b;
                    pendHalf = 1'b1;
                    bitInFrame++;
                end
                sinceStrobe = 0;
            end
        end
    end

    // Frame-level model: nFrames complete frames, the run stopping after the last one.
    task automatic pushRun(input int nFrames);
        logic [15:0]       mk;
        logic [WORD_W-1:0] w;
        bitExp_t           it;
        mk = MARKER;
        for (int f = 0; f < nFrames; f++) begin
            for (int wi = 0; wi < FRAME_WORDS; wi++) begin
                w    = ram[wi];
                w[0] = mk[15 - (wi % 16)];
                reQ.push_back(wi);
                for (int i = WORD_W - 1; i >= 0; i--) begin
                    it.b     = w[i];
                    it.fs    = (wi == 0) && (i == WORD_W - 1);
                    it.first = (f == 0) && it.fs;
                    bitQ.push_back(it);
                end
            end
        end
    endtask

    task automatic randomizeRam();
        for (int n = 0; n < FRAME_WORDS; n++) ram[n] = WORD_W'($urandom);
    endtask

    task automatic waitFor(input int frames, input int bits, input string what);
        int n;
        n = 0;
        while (!(frameCnt >= frames && bitInFrame >= bits) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check(what, (n >= 20000), 0);
    endtask

    task automatic checkReset();
        check("rst_rdaddr", RdAddr, 0);
        check("rst_re", RE, 0);
        check("rst_sw", SW, 0);
        check("rst_serout", serOut, 0);
        check("rst_bitstrobe", bitStrobe, 0);
        check("rst_framestart", frameStart, 0);
    endtask

    // One enabled run of nFrames, en dropped once word dropWord of the last frame has started.
    task automatic runSegment(input int nFrames, input int dropWord);
        int   base;
        int   n;
        logic sawHigh;
        base = frameCnt;
        pushRun(nFrames);
        en = 1'b1;
        waitFor(base + nFrames, dropWord * WORD_W + 1, "wait_drop_point");
        en = 1'b0;
        n = 0;
        while ((bitQ.size() != 0 || reQ.size() != 0) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("run_drained", (n >= 20000), 0);
        repeat (2 * DIV + 2) @(posedge clk);
        #1;
        sawHigh = 1'b0;
        for (int c = 0; c < 3 * WORD_W * DIV; c++) begin
            if (serOut !== 1'b0) sawHigh = 1'b1;
            @(posedge clk); #1;
        end
        check("idle_serout", sawHigh, 0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        en  = 1'b0;
        for (int n = 0; n < FRAME_WORDS; n++) ram[n] = WORD_W'(n);
        repeat (3) @(posedge clk);
        #1;
        checkReset();
        rst = 1'b0;

        // Counting pattern, three frames, en dropped at word 10 of the last one.
        runSegment(3, 10);

        // Random contents, random stop point.
        randomizeRam();
        runSegment(2, int'($urandom_range(1, FRAME_WORDS - 2)));

        // Reset in the middle of bit 7 of word 5.
        randomizeRam();
        base = frameCnt;
        pushRun(1);
        en = 1'b1;
        waitFor(base + 1, 5 * WORD_W + (WORD_W - 1 - 7) + 1, "wait_reset_point");
        rst = 1'b1;
        en  = 1'b0;
        bitQ.delete();
        reQ.delete();
        @(posedge clk); #1;
        checkReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Restart after reset with fresh random contents.
        randomizeRam();
        runSegment(2, int'($urandom_range(1, FRAME_WORDS - 2)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
